core_sequencer: RTL
===================

# core_sequencer

Second-generation core controller sequencing the memory controller (MC) and processing unit for the data-path core. Commands arrive as an instruction plus data size and are held in a parametrised command queue, so the host can post the next job while the current one runs. Each job is stepped through store, transfer and processing phases using the same 3-bit data-condition encoding the MC already decodes. A per-phase watchdog traps hung handshakes into a sticky error state.

## Interface
Parameters:
- INST_W, 3, instruction (op-code) width
- LEN_W, 6, data-length width
- QDEPTH, 2, command queue depth; power of two, ≥2
- TIMEOUT, 255, max cycles allowed in any wait state before error; 1..2^16-1

Ports:
- ctrl_clk  in  1  clock, rising edge
- ctrl_reset  in  1  reset; asynchronous, active-high
- ctrl_valid_inst  in  1  instruction valid
- ctrl_valid_data  in  1  data valid; command offered only when both valids high
- ctrl_instruction  in  INST_W  op-code of offered command
- ctrl_data_in_size  in  LEN_W  data length of offered command
- ctrl_ready  out  1  queue can accept (combinational: not full and not ERROR)
- mc_done  in  1  MC phase complete
- mc_data_done  in  1  MC has no more data for the current job
- procc_done  in  1  processing pass complete
- ctrl_data_contition  out  3  100 input→mem, 010 mem→reg, 001 data in reg, 000 none
- mc_data_length  out  LEN_W  length of current job
- procc_instruction  out  INST_W  op-code of current job
- procc_start  out  1  one-cycle pulse starting a processing pass
- job_done  out  1  one-cycle pulse on job completion
- pass_count  out  8  processing passes started in current job; wraps at 255→0
- ctrl_busy  out  1  state ≠ IDLE
- ctrl_error  out  1  sticky watchdog error
- ctrl_err_clr  in  1  clears error; effective only in ERROR

## Operation
- Accept: valid_inst & valid_data & ctrl_ready at a rising edge pushes {instruction, size}. Ready uses pre-edge occupancy; push refused when full even if popping same edge.
- States: IDLE, STORE, TRANS, PROC, ERROR.
- IDLE: queue non-empty → pop; mc_data_length←size; procc_instruction←instruction; pass_count←0; contition←100; →STORE. Popped size 0 → no MC activity, job_done pulse, stay IDLE.
- STORE: mc_done → contition←010, →TRANS.
- TRANS: mc_done → contition←001, procc_start←1, pass_count+1, →PROC.
- PROC: procc_start←0 after one cycle. mc_data_done → contition←000, job_done pulse, →IDLE. Else procc_done → contition←010, →TRANS. mc_data_done wins when both high same cycle. mc_done ignored in PROC.
- Watchdog: 16-bit counter cleared on every state change; increments each cycle in STORE/TRANS/PROC. Reaching TIMEOUT with no exit event → ERROR: contition←000, procc_start←0, ctrl_error←1, queue flushed. Exit event on the same edge as expiry wins.
- ERROR: ctrl_ready=0, inputs ignored; ctrl_err_clr → ctrl_error←0, →IDLE.

## Timing
- Reset (async, immediate): state IDLE, queue empty, contition 000, mc_data_length 0, procc_instruction 0, procc_start 0, job_done 0, pass_count 0, ctrl_error 0; ctrl_ready=1. Reset mid-job aborts and flushes.
- Accept at edge k into empty queue in IDLE → contition=100 after edge k+1.
- mc_done at edge in TRANS → procc_start high for exactly the following cycle.
- All outputs registered except ctrl_ready and ctrl_busy (decoded from state/occupancy).
- Queue order FIFO; pointers wrap modulo QDEPTH.

## Test plan
- Single job inst=3'b101, size=6'd12; mc_done, mc_done, mc_data_done → contition 100→010→001→000, procc_instruction=101, procc_start 1 cycle, job_done 1 cycle, pass_count=1.
- Multi-pass: procc_done twice then mc_data_done → TRANS/PROC alternate, pass_count=3, exactly three procc_start pulses.
- Backpressure QDEPTH=2: post 3 commands during a job → ctrl_ready low after 2nd, 3rd held; jobs execute in order with correct lengths.
- Size 0 command followed by size 5 → first gives job_done with contition staying 000, second enters STORE next.
- Watchdog TIMEOUT=10: withhold mc_done in STORE → after 10 cycles ctrl_error=1, contition=000, ctrl_ready=0, queue empty; ctrl_err_clr → IDLE, ready=1.
- mc_data_done and procc_done same cycle in PROC → IDLE; async reset mid-TRANS → all outputs reset values immediately.

Source files
------------

// File: rtl/core_sequencer_if.sv
// Host / MC / processing-unit bus for core_sequencer.
// The sequencer sits on the slave side; the environment drives the master side.
interface core_sequencer_if #(
  parameter int INST_W = 3,
  parameter int LEN_W  = 6
);
  // host command channel
  logic              ctrl_valid_inst;
  logic              ctrl_valid_data;
  logic [INST_W-1:0] ctrl_instruction;
  logic [LEN_W-1:0]  ctrl_data_in_size;
  logic              ctrl_ready;
  // MC / processing-unit handshakes
  logic              mc_done;
  logic              mc_data_done;
  logic              procc_done;
  logic [2:0]        ctrl_data_contition;
  logic [LEN_W-1:0]  mc_data_length;
  logic [INST_W-1:0] procc_instruction;
  logic              procc_start;
  // status
  logic              job_done;
  logic [7:0]        pass_count;
  logic              ctrl_busy;
  logic              ctrl_error;
  logic              ctrl_err_clr;

  modport master (
    output ctrl_valid_inst, ctrl_valid_data, ctrl_instruction, ctrl_data_in_size,
    output mc_done, mc_data_done, procc_done, ctrl_err_clr,
    input  ctrl_ready, ctrl_data_contition, mc_data_length, procc_instruction,
    input  procc_start, job_done, pass_count, ctrl_busy, ctrl_error
  );

  modport slave (
    input  ctrl_valid_inst, ctrl_valid_data, ctrl_instruction, ctrl_data_in_size,
    input  mc_done, mc_data_done, procc_done, ctrl_err_clr,
    output ctrl_ready, ctrl_data_contition, mc_data_length, procc_instruction,
    output procc_start, job_done, pass_count, ctrl_busy, ctrl_error
  );
endinterface

// File: rtl/core_sequencer.sv
// Core sequencer: buffers {instruction, size} commands in a small FIFO and
// steps each job through MC store, transfer and processing phases, with a
// per-phase watchdog that traps stalled handshakes into a sticky error.
module core_sequencer #(
  parameter int INST_W  = 3,
  parameter int LEN_W   = 6,
  parameter int QDEPTH  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic            ctrl_clk,
  input  logic            ctrl_reset,
  core_sequencer_if.slave bus
);
  localparam int              PTR_W    = $clog2(QDEPTH);
  localparam logic [PTR_W:0]  Q_FULL   = QDEPTH[PTR_W:0];
  localparam logic [PTR_W:0]  CNT_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [15:0]     WD_LAST  = 16'(TIMEOUT - 1);

  // MC data-condition encoding
  localparam logic [2:0] COND_NONE    = 3'b000;
  localparam logic [2:0] COND_IN2MEM  = 3'b100;
  localparam logic [2:0] COND_MEM2REG = 3'b010;
  localparam logic [2:0] COND_INREG   = 3'b001;

  typedef enum logic [2:0] {S_IDLE, S_STORE, S_TRANS, S_PROC, S_ERROR} state_e;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  state_e              state_q, state_d;
  cmd_t [QDEPTH-1:0]   mem_q, mem_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [2:0]          cond_q, cond_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic [7:0]          pass_q, pass_d;
  logic                err_q, err_d;
  logic [15:0]         wd_q, wd_d;

  logic full, empty, ready, push, pop, trap, wd_expired;
  cmd_t head;

  assign full       = (count_q == Q_FULL);
  assign empty      = (count_q == '0);
  assign ready      = !full && (state_q != S_ERROR);
  assign push       = bus.ctrl_valid_inst && bus.ctrl_valid_data && ready;
  assign head       = mem_q[rd_ptr_q];
  assign wd_expired = (wd_q == WD_LAST);

  assign bus.ctrl_ready          = ready;
  assign bus.ctrl_busy           = (state_q != S_IDLE);
  assign bus.ctrl_data_contition = cond_q;
  assign bus.mc_data_length      = len_q;
  assign bus.procc_instruction   = inst_q;
  assign bus.procc_start         = start_q;
  assign bus.job_done            = done_q;
  assign bus.pass_count          = pass_q;
  assign bus.ctrl_error          = err_q;

  // Next-state, job outputs, watchdog and command FIFO bookkeeping
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cond_d   = cond_q;
    len_d    = len_q;
    inst_d   = inst_q;
    pass_d   = pass_q;
    err_d    = err_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    wd_d     = 16'd0;
    pop      = 1'b0;
    trap     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          len_d  = head.len;
          inst_d = head.inst;
          pass_d = 8'd0;
          // zero-length jobs complete without touching the MC
          if (head.len == '0) begin
            done_d = 1'b1;
          end else begin
            cond_d  = COND_IN2MEM;
            state_d = S_STORE;
          end
        end
      end
      S_STORE: begin
        if (bus.mc_done) begin
          cond_d  = COND_MEM2REG;
          state_d = S_TRANS;
        end else if (wd_expired) begin
          trap = 1'b1;
        end
      end
      S_TRANS: begin
        if (bus.mc_done) begin
          cond_d  = COND_INREG;
          start_d = 1'b1;
          pass_d  = pass_q + 8'd1;
          state_d = S_PROC;
        end else if (wd_expired) begin
          trap = 1'b1;
        end
      end
      S_PROC: begin
        // end-of-data takes priority over another processing pass
        if (bus.mc_data_done) begin
          cond_d  = COND_NONE;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (bus.procc_done) begin
          cond_d  = COND_MEM2REG;
          state_d = S_TRANS;
        end else if (wd_expired) begin
          trap = 1'b1;
        end
      end
      S_ERROR: begin
        if (bus.ctrl_err_clr) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (trap) begin
      state_d = S_ERROR;
      cond_d  = COND_NONE;
      err_d   = 1'b1;
    end

    // watchdog restarts on every state change
    if ((state_d == state_q) &&
        (state_q == S_STORE || state_q == S_TRANS || state_q == S_PROC))
      wd_d = wd_q + 16'd1;

    // an error trap discards everything queued, including a same-edge push
    if (trap) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {bus.ctrl_instruction, bus.ctrl_data_in_size};
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q  <= S_IDLE;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cond_q   <= COND_NONE;
      len_q    <= '0;
      inst_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 8'd0;
      err_q    <= 1'b0;
      wd_q     <= 16'd0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cond_q   <= cond_d;
      len_q    <= len_d;
      inst_q   <= inst_d;
      start_q  <= start_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end
endmodule
